// File: rtl/mixer_div_pkg.sv
// Shared definitions for the mixer's iterative signed divider.
package mixer_div_pkg;

  localparam int DEF_W = 71;
  localparam int DEF_D = 13;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;

  localparam logic signed [DEF_W-1:0] QMAX = {1'b0, {(DEF_W-1){1'b1}}};
  localparam logic signed [DEF_W-1:0] QMIN = {1'b1, {(DEF_W-1){1'b0}}};

endpackage

// File: rtl/mixer_sdiv_step.sv
// One radix-2 restoring step on unsigned magnitudes: shift in a dividend bit,
// compare against the divisor and subtract when it fits.
module mixer_sdiv_step
  import mixer_div_pkg::*;
#(
  parameter int D = DEF_D
) (
  input  logic [D-1:0] rem,
  input  logic         din,
  input  logic [D-1:0] dvsr,
  output logic [D-1:0] rem_nxt,
  output logic         qbit
);

  logic [D-1:0] partial;

  // The shifted partial remainder needs D+1 bits; its top bit is rem's MSB,
  // and when that bit is set the partial always exceeds the divisor.
  always_comb begin
    partial = {rem[D-2:0], din};
    qbit    = rem[D-1] || (partial >= dvsr);
    rem_nxt = qbit ? (partial - dvsr) : partial;
  end

endmodule

// File: rtl/mixer_sdiv_seq.sv
// Iterative signed divider (W-bit dividend / D-bit divisor), one quotient bit per cycle.
// Define MIXER_SDIV_ROUND_EN to round the quotient half away from zero.
module mixer_sdiv_seq
  import mixer_div_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DEF_W,
  parameter int DIVISOR_WIDTH  = DEF_D
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [DIVIDEND_WIDTH-1:0] dividend,
  input  logic signed [DIVISOR_WIDTH-1:0]  divisor,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [DIVIDEND_WIDTH-1:0] quotient,
  output logic signed [DIVISOR_WIDTH-1:0]  remainder,
  output logic                             div_by_zero,
  output logic                             overflow
);

  localparam int W  = DIVIDEND_WIDTH;
  localparam int D  = DIVISOR_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [W-1:0]        MAG_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] Q_MAX   = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] Q_MIN   = MAG_MIN;

  div_state_t          state;
  logic [CW-1:0]       cnt;
  logic [W-1:0]        dq;
  logic [D-1:0]        rem;
  logic [D-1:0]        dvsr;
  logic [D-1:0]        rem_nxt;
  logic                qbit;
  logic                sign_q;
  logic                sign_r;
  logic                dbz;
  logic                ovf;
  logic [W-1:0]        dend_mag;
  logic [D-1:0]        dsor_mag;
  logic signed [W-1:0] fix_q;
  logic signed [D-1:0] fix_r;
`ifdef MIXER_SDIV_ROUND_EN
  logic [W:0]          qm;
`endif

  assign in_ready = (state == IDLE);
  assign dend_mag = dividend[W-1] ? (~dividend + 1'b1) : dividend;
  assign dsor_mag = divisor[D-1] ? (~divisor + 1'b1) : divisor;

  mixer_sdiv_step #(.D(D)) u_step (
    .rem     (rem),
    .din     (dq[W-1]),
    .dvsr    (dvsr),
    .rem_nxt (rem_nxt),
    .qbit    (qbit)
  );

  // Sign application; dq holds the quotient magnitude once CALC has finished.
  always_comb begin
    fix_r = sign_r ? (~rem + 1'b1) : rem;
`ifdef MIXER_SDIV_ROUND_EN
    qm = {1'b0, dq} + {{W{1'b0}}, ({rem, 1'b0} >= {1'b0, dvsr})};
    if (qm >= {1'b0, MAG_MIN}) fix_q = sign_q ? Q_MIN : Q_MAX;
    else                       fix_q = sign_q ? (~qm[W-1:0] + 1'b1) : qm[W-1:0];
`else
    fix_q = sign_q ? (~dq + 1'b1) : dq;
`endif
    if (dbz) begin
      fix_q = sign_r ? Q_MIN : Q_MAX;
      fix_r = '0;
    end else if (ovf) begin
      fix_q = Q_MAX;
      fix_r = '0;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dq          <= '0;
      rem         <= '0;
      dvsr        <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dbz         <= 1'b0;
      ovf         <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dq     <= dend_mag;
            dvsr   <= dsor_mag;
            rem    <= '0;
            sign_q <= dividend[W-1] ^ divisor[D-1];
            sign_r <= dividend[W-1];
            dbz    <= (divisor == '0);
            ovf    <= (dividend == Q_MIN) && (divisor == '1);
            cnt    <= CW'(W-1);
            state  <= CALC;
          end
        end
        // dividend bits leave dq's MSB while quotient bits enter at its LSB
        CALC: begin
          rem <= rem_nxt;
          dq  <= {dq[W-2:0], qbit};
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          quotient    <= fix_q;
          remainder   <= fix_r;
          div_by_zero <= dbz;
          overflow    <= ovf;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mixer_sdiv_seq.sv
// Directed scoreboard bench for mixer_sdiv_seq; expected results come from
// SystemVerilog's own signed / and % on widened operands.
module tb_mixer_sdiv_seq;
  import mixer_div_pkg::*;

  localparam int W   = DEF_W;
  localparam int D   = DEF_D;
  localparam int LAT = W + 1;

  logic                ap_clk    = 1'b0;
  logic                ap_rst    = 1'b1;
  logic                in_valid  = 1'b0;
  logic                out_ready = 1'b0;
  logic signed [W-1:0] dividend  = '0;
  logic signed [D-1:0] divisor   = '0;
  logic                in_ready;
  logic                out_valid;
  logic signed [W-1:0] quotient;
  logic signed [D-1:0] remainder;
  logic                div_by_zero;
  logic                overflow;

  typedef struct {
    logic signed [W-1:0] q;
    logic signed [D-1:0] r;
    logic                dbz;
    logic                ovf;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  always #5 ap_clk = ~ap_clk;

  mixer_sdiv_seq dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  task automatic checkEq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference result: truncating signed divide, plus saturation and optional rounding.
  function automatic exp_t model(input logic signed [W-1:0] a, input logic signed [D-1:0] b);
    exp_t e;
    logic signed [127:0] sa, sd, q, r, qmax, qmin;
    sa = a;
    sd = b;
    qmax = QMAX;
    qmin = QMIN;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (sd == 0) begin
      e.dbz = 1'b1;
      e.q   = (sa < 0) ? QMIN : QMAX;
      e.r   = '0;
    end else if (sa == qmin && sd == -1) begin
      e.ovf = 1'b1;
      e.q   = QMAX;
      e.r   = '0;
    end else begin
      q = sa / sd;
      r = sa % sd;
`ifdef MIXER_SDIV_ROUND_EN
      if (2 * ((r < 0) ? -r : r) >= ((sd < 0) ? -sd : sd)) begin
        q = ((sa < 0) != (sd < 0)) ? q - 1 : q + 1;
        if (q > qmax) q = qmax;
        if (q < qmin) q = qmin;
      end
`endif
      e.q = q[W-1:0];
      e.r = r[D-1:0];
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic signed [W-1:0] a, input logic signed [D-1:0] b);
    int waitCnt;
    waitCnt = 0;
    @(negedge ap_clk);
    while (!in_ready && waitCnt < 200) begin
      @(negedge ap_clk);
      waitCnt++;
    end
    checkEq("in_ready_idle", in_ready, 1'b1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    sb.push_back(model(a, b));
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    dividend = ~a;
    divisor  = ~b;
  endtask

  // Waits for the result, scores it, optionally stalls the consumer, then acknowledges.
  task automatic checkOutput(input int hold);
    exp_t e;
    int   lat;
    lat = 0;
    do begin
      lat++;
      @(posedge ap_clk);
      #1;
    end while (!out_valid && lat < 200);
    checkEq("latency", lat, LAT);
    if (sb.size() == 0) begin
      checkEq("scoreboard_nonempty", 1'b0, 1'b1);
      return;
    end
    e = sb.pop_front();
    checkEq("quotient", quotient, e.q);
    checkEq("remainder", remainder, e.r);
    checkEq("div_by_zero", div_by_zero, e.dbz);
    checkEq("overflow", overflow, e.ovf);
    checkEq("in_ready_busy", in_ready, 1'b0);
    if (hold > 0) begin
      in_valid = 1'b1;
      dividend = 5;
      divisor  = 1;
      repeat (hold) @(posedge ap_clk);
      #1;
      checkEq("hold_out_valid", out_valid, 1'b1);
      checkEq("hold_quotient", quotient, e.q);
      checkEq("hold_remainder", remainder, e.r);
      checkEq("hold_div_by_zero", div_by_zero, e.dbz);
      checkEq("hold_overflow", overflow, e.ovf);
      checkEq("hold_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    out_ready = 1'b0;
    checkEq("ack_out_valid", out_valid, 1'b0);
    checkEq("ack_flags", {div_by_zero, overflow}, 2'b00);
    checkEq("ack_in_ready", in_ready, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic runDiv(input logic signed [W-1:0] a, input logic signed [D-1:0] b, input int hold);
    applyStimulus(a, b);
    checkOutput(hold);
  endtask

  initial begin
    logic [95:0] rnd;
    logic [31:0] rnd2;
    logic        seen;

    $display("[TB] mixer_sdiv_seq bench start");
    repeat (3) @(negedge ap_clk);
    checkEq("rst_in_ready", in_ready, 1'b1);
    checkEq("rst_out_valid", out_valid, 1'b0);
    checkEq("rst_quotient", quotient, '0);
    checkEq("rst_remainder", remainder, '0);
    checkEq("rst_flags", {div_by_zero, overflow}, 2'b00);
    ap_rst = 1'b0;

    runDiv(100, 7, 0);
    runDiv(-100, 7, 0);
    runDiv(100, -7, 0);
    runDiv(100, 0, 10);
    runDiv(-5, 0, 0);
    runDiv(QMIN, -1, 0);
    runDiv(QMIN, 1, 0);
    runDiv(-7, 2, 0);
    runDiv(71'sh12_3456_789A_BCDE_F012, 13'sd1234, 0);
    runDiv(-(71'sh3F_0000_1111_2222_3333), -13'sd4096, 0);
    for (int i = 0; i < 3; i++) begin
      rnd  = {$urandom(), $urandom(), $urandom()};
      rnd2 = $urandom();
      runDiv(rnd[W-1:0], rnd2[D-1:0], i);
    end

    // Abort a division mid-CALC with reset; nothing may come out of it.
    applyStimulus(1234567, 3);
    repeat (30) @(posedge ap_clk);
    #1;
    ap_rst = 1'b1;
    #1;
    checkEq("abort_out_valid", out_valid, 1'b0);
    checkEq("abort_in_ready", in_ready, 1'b1);
    checkEq("abort_quotient", quotient, '0);
    checkEq("abort_remainder", remainder, '0);
    sb.delete(sb.size() - 1);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    seen = 1'b0;
    repeat (100) begin
      @(posedge ap_clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    checkEq("abort_no_result", seen, 1'b0);

    runDiv(9, 2, 0);

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
